// File: rtl/rv32i_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small transmit FIFO.
// Ports: clk, reset (async, active-low); io_we/io_addr/io_wdata from the
// memory stage; io_rdata registered STATUS read data; tx serial line.
module rv32i_uart_tx #(
  parameter int          CLKS_PER_BIT = 87,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_8010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_we,
  input  logic [29:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [29:0] DATA_A = BASE_ADDR[31:2];
  localparam logic [29:0] STAT_A = BASE_ADDR[31:2] + 30'd1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          ovf;

  logic        hit_data;
  logic        hit_stat;
  logic        full;
  logic        empty;
  logic        bit_end;
  logic        pop;
  logic        push_req;
  logic        push;
  logic        ovf_set;
  logic        ovf_clr;
  logic        busy;
  logic [31:0] status;
  logic        unused;

  assign unused = ^io_wdata[31:8];

  assign hit_data = (io_addr == DATA_A);
  assign hit_stat = (io_addr == STAT_A);

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign bit_end = (cnt == CNT_MAX);
  assign busy    = (state != S_IDLE);

  // The FSM takes the head either from IDLE or at the end of a stop
  // bit, which is what makes back-to-back frames gapless.
  assign pop = !empty &&
    ((state == S_IDLE) ||
     ((state == S_STOP) && bit_end));

  assign push_req = io_we && hit_data;
  // A pop in the same cycle frees the slot, so a full FIFO still
  // accepts the push.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = io_we && hit_stat && io_wdata[3];

  assign status = {
    23'd0,
    5'(count),
    ovf,
    empty,
    full,
    busy
  };

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= io_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_rdata <= '0;
    end else begin
      unique case (1'b1)
        hit_stat: io_rdata <= status;
        default:  io_rdata <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (pop) begin
            shift   <= mem[rptr];
            bit_idx <= '0;
            tx      <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt   <= '0;
            tx    <= shift[0];
            state <= S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (pop) begin
              shift   <= mem[rptr];
              bit_idx <= '0;
              tx      <= 1'b0;
              state   <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
